// File: rtl/idecode.sv
// RV32I decode stage: main/ALU decoders, immediate extension, register file and ID/EX register.
// Optional macro IDECODE_BYPASS_EN: same-edge writeback data is forwarded through the read ports.
module idecode #(
  parameter int NREGS    = 32,
  parameter bit RF_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        FlushE,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  output logic [4:0]  Rs1D,
  output logic [4:0]  Rs2D,
  output logic        RegWriteE,
  output logic [1:0]  ResultSrcE,
  output logic        MemWriteE,
  output logic        JumpE,
  output logic        BranchE,
  output logic [2:0]  ALUControlE,
  output logic        ALUSrcE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] PCE,
  output logic [31:0] ImmExtE,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE,
  output logic [31:0] PCPlus4E,
  output logic        IllegalE
);

  localparam int AW = $clog2(NREGS);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_J    = 3'd4
  } imm_src_e;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic [2:0]  alu_control;
    logic        alu_src;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [31:0] imm_ext;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc_plus4;
    logic        illegal;
  } idex_t;

  logic [6:0]    w_opcode;
  logic [2:0]    w_funct3;
  logic          w_funct7b5;
  logic [AW-1:0] w_rs1_idx;
  logic [AW-1:0] w_rs2_idx;
  logic [AW-1:0] w_rd_idx;
  logic          w_rf_we;

  assign w_opcode   = InstrD[6:0];
  assign w_funct3   = InstrD[14:12];
  assign w_funct7b5 = InstrD[30];
  assign Rs1D       = InstrD[19:15];
  assign Rs2D       = InstrD[24:20];
  assign w_rs1_idx  = AW'(InstrD[19:15]);
  assign w_rs2_idx  = AW'(InstrD[24:20]);
  assign w_rd_idx   = AW'(RdW);
  assign w_rf_we    = RegWriteW && (RdW != 5'd0) && (w_rd_idx != '0);

  // Register file; entry 0 is never written, so it stays at its reset/initial value and reads are forced to 0.
  logic [31:0] r_rf [NREGS];

  generate
    if (RF_RESET) begin : g_rf_rst
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
        end else if (w_rf_we) begin
          r_rf[w_rd_idx] <= ResultW;
        end
      end
    end else begin : g_rf_norst
      always_ff @(posedge clk) begin
        if (w_rf_we) r_rf[w_rd_idx] <= ResultW;
      end
    end
  endgenerate

  logic [31:0] w_rd1;
  logic [31:0] w_rd2;

  always_comb begin
    w_rd1 = (Rs1D == 5'd0) ? 32'd0 : r_rf[w_rs1_idx];
    w_rd2 = (Rs2D == 5'd0) ? 32'd0 : r_rf[w_rs2_idx];
`ifdef IDECODE_BYPASS_EN
    if (w_rf_we && (RdW == Rs1D)) w_rd1 = ResultW;
    if (w_rf_we && (RdW == Rs2D)) w_rd2 = ResultW;
`endif
  end

  // Main decoder.
  logic     w_reg_write;
  logic [1:0] w_result_src;
  logic     w_mem_write;
  logic     w_jump;
  logic     w_branch;
  logic     w_alu_src;
  logic [1:0] w_alu_op;
  imm_src_e w_imm_src;
  logic     w_illegal_op;

  always_comb begin
    w_reg_write  = 1'b0;
    w_result_src = 2'b00;
    w_mem_write  = 1'b0;
    w_jump       = 1'b0;
    w_branch     = 1'b0;
    w_alu_src    = 1'b0;
    w_alu_op     = 2'b00;
    w_imm_src    = IMM_NONE;
    w_illegal_op = 1'b0;
    case (w_opcode)
      OP_LW: begin
        w_reg_write  = 1'b1;
        w_imm_src    = IMM_I;
        w_alu_src    = 1'b1;
        w_result_src = 2'b01;
      end
      OP_SW: begin
        w_mem_write = 1'b1;
        w_imm_src   = IMM_S;
        w_alu_src   = 1'b1;
      end
      OP_R: begin
        w_reg_write = 1'b1;
        w_alu_op    = 2'b10;
      end
      OP_IALU: begin
        w_reg_write = 1'b1;
        w_imm_src   = IMM_I;
        w_alu_src   = 1'b1;
        w_alu_op    = 2'b10;
      end
      OP_BEQ: begin
        w_branch  = 1'b1;
        w_imm_src = IMM_B;
        w_alu_op  = 2'b01;
      end
      OP_JAL: begin
        w_reg_write  = 1'b1;
        w_jump       = 1'b1;
        w_imm_src    = IMM_J;
        w_result_src = 2'b10;
      end
      default: w_illegal_op = 1'b1;
    endcase
  end

  // ALU decoder; unsupported funct3 under ALUOp 10 marks the instruction illegal.
  logic [2:0] w_alu_control;
  logic       w_illegal_f3;

  always_comb begin
    w_alu_control = ALU_ADD;
    w_illegal_f3  = 1'b0;
    case (w_alu_op)
      2'b01: w_alu_control = ALU_SUB;
      2'b10: begin
        case (w_funct3)
          3'b000:  w_alu_control = ((w_opcode == OP_R) && w_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  w_alu_control = ALU_SLT;
          3'b110:  w_alu_control = ALU_OR;
          3'b111:  w_alu_control = ALU_AND;
          default: w_illegal_f3  = 1'b1;
        endcase
      end
      default: w_alu_control = ALU_ADD;
    endcase
  end

  logic [31:0] w_imm_ext;

  always_comb begin
    w_imm_ext = 32'd0;
    case (w_imm_src)
      IMM_I:   w_imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
      IMM_S:   w_imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B:   w_imm_ext = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      IMM_J:   w_imm_ext = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
      default: w_imm_ext = 32'd0;
    endcase
  end

  logic  w_illegal;
  idex_t w_next;

  assign w_illegal = w_illegal_op || w_illegal_f3;

  always_comb begin
    w_next             = '0;
    w_next.reg_write   = w_reg_write  && !w_illegal;
    w_next.result_src  = w_illegal ? 2'b00 : w_result_src;
    w_next.mem_write   = w_mem_write  && !w_illegal;
    w_next.jump        = w_jump       && !w_illegal;
    w_next.branch      = w_branch     && !w_illegal;
    w_next.alu_control = w_illegal ? ALU_ADD : w_alu_control;
    w_next.alu_src     = w_alu_src    && !w_illegal;
    w_next.rd1         = w_rd1;
    w_next.rd2         = w_rd2;
    w_next.pc          = PCD;
    w_next.imm_ext     = w_imm_ext;
    w_next.rs1         = Rs1D;
    w_next.rs2         = Rs2D;
    w_next.rd          = InstrD[11:7];
    w_next.pc_plus4    = PCPlus4D;
    w_next.illegal     = w_illegal;
  end

  // ID/EX register; a flush loads an all-zero bubble.
  idex_t r_idex;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idex <= '0;
    end else if (FlushE) begin
      r_idex <= '0;
    end else begin
      r_idex <= w_next;
    end
  end

  assign RegWriteE   = r_idex.reg_write;
  assign ResultSrcE  = r_idex.result_src;
  assign MemWriteE   = r_idex.mem_write;
  assign JumpE       = r_idex.jump;
  assign BranchE     = r_idex.branch;
  assign ALUControlE = r_idex.alu_control;
  assign ALUSrcE     = r_idex.alu_src;
  assign RD1E        = r_idex.rd1;
  assign RD2E        = r_idex.rd2;
  assign PCE         = r_idex.pc;
  assign ImmExtE     = r_idex.imm_ext;
  assign Rs1E        = r_idex.rs1;
  assign Rs2E        = r_idex.rs2;
  assign RdE         = r_idex.rd;
  assign PCPlus4E    = r_idex.pc_plus4;
  assign IllegalE    = r_idex.illegal;

endmodule

// File: tb/tb_idecode.sv
// Scoreboard bench for idecode: driver pushes reference-model results, monitor pops and compares after each edge.
module tb_idecode;

  logic        clk;
  logic        reset;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        FlushE;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic [4:0]  Rs1D;
  logic [4:0]  Rs2D;
  logic        RegWriteE;
  logic [1:0]  ResultSrcE;
  logic        MemWriteE;
  logic        JumpE;
  logic        BranchE;
  logic [2:0]  ALUControlE;
  logic        ALUSrcE;
  logic [31:0] RD1E;
  logic [31:0] RD2E;
  logic [31:0] PCE;
  logic [31:0] ImmExtE;
  logic [4:0]  Rs1E;
  logic [4:0]  Rs2E;
  logic [4:0]  RdE;
  logic [31:0] PCPlus4E;
  logic        IllegalE;

  idecode dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .FlushE(FlushE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
    .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE),
    .ALUSrcE(ALUSrcE), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .PCPlus4E(PCPlus4E), .IllegalE(IllegalE)
  );

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic [2:0]  alu_ctrl;
    logic        alu_src;
    logic        illegal;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } eout_t;

  localparam int EW = $bits(eout_t);

  logic [EW-1:0] exp_q[$];
  logic [31:0]   m_rf [32];
  int            n_checks;
  int            n_fail;
  eout_t         act;

  assign act = '{reg_write: RegWriteE, result_src: ResultSrcE, mem_write: MemWriteE,
                 jump: JumpE, branch: BranchE, alu_ctrl: ALUControlE, alu_src: ALUSrcE,
                 illegal: IllegalE, rd1: RD1E, rd2: RD2E, imm: ImmExtE, pc: PCE,
                 pcp4: PCPlus4E, rs1: Rs1E, rs2: Rs2E, rd: RdE};

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, 64'({act.reg_write, act.result_src, act.mem_write, act.jump,
                                act.branch, act.alu_ctrl, act.alu_src, act.illegal}), 64'd0);
    check({name, "_data"}, 64'(act.rd1 | act.rd2 | act.imm | act.pc | act.pcp4), 64'd0);
    check({name, "_idx"}, 64'({act.rs1, act.rs2, act.rd}), 64'd0);
  endtask

  // Reference model
  function automatic logic [31:0] rf_read(input logic [4:0] idx, input logic we,
                                          input logic [4:0] rd, input logic [31:0] res);
    if (idx == 5'd0) return 32'd0;
`ifdef IDECODE_BYPASS_EN
    if (we && rd == idx) return res;
`endif
    return m_rf[idx];
  endfunction

  function automatic eout_t model(input logic [31:0] instr, input logic [31:0] pc,
                                  input logic flush, input logic [31:0] rd1, input logic [31:0] rd2);
    eout_t e;
    logic [6:0] op;
    logic [2:0] f3;
    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic signed [12:0] imm_b;
    logic signed [20:0] imm_j;
    logic use_f3;
    e      = '0;
    op     = instr[6:0];
    f3     = instr[14:12];
    imm_i  = instr[31:20];
    imm_s  = {instr[31:25], instr[11:7]};
    imm_b  = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    imm_j  = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    use_f3 = 1'b0;
    if (flush) return e;
    e.rd1  = rd1;
    e.rd2  = rd2;
    e.pc   = pc;
    e.pcp4 = pc + 32'd4;
    e.rs1  = instr[19:15];
    e.rs2  = instr[24:20];
    e.rd   = instr[11:7];
    case (op)
      7'b0000011: begin e.reg_write = 1; e.alu_src = 1; e.result_src = 2'b01; e.imm = 32'(imm_i); end
      7'b0100011: begin e.mem_write = 1; e.alu_src = 1; e.imm = 32'(imm_s); end
      7'b0110011: begin e.reg_write = 1; use_f3 = 1; end
      7'b0010011: begin e.reg_write = 1; e.alu_src = 1; use_f3 = 1; e.imm = 32'(imm_i); end
      7'b1100011: begin e.branch = 1; e.alu_ctrl = 3'b001; e.imm = 32'(imm_b); end
      7'b1101111: begin e.reg_write = 1; e.jump = 1; e.result_src = 2'b10; e.imm = 32'(imm_j); end
      default:    e.illegal = 1;
    endcase
    if (use_f3) begin
      if (f3 == 3'b000)      e.alu_ctrl = (op == 7'b0110011 && instr[30]) ? 3'b001 : 3'b000;
      else if (f3 == 3'b010) e.alu_ctrl = 3'b101;
      else if (f3 == 3'b110) e.alu_ctrl = 3'b011;
      else if (f3 == 3'b111) e.alu_ctrl = 3'b010;
      else                   e.illegal  = 1;
    end
    if (e.illegal) begin
      e.reg_write = 0; e.result_src = 0; e.mem_write = 0; e.jump = 0;
      e.branch = 0; e.alu_ctrl = 0; e.alu_src = 0;
    end
    return e;
  endfunction

  // Driver: called at a falling edge, drives inputs for the next rising edge and returns at the following falling edge.
  task automatic step(input logic [31:0] instr, input logic flush, input logic we,
                      input logic [4:0] rd, input logic [31:0] res);
    logic [31:0] pc;
    eout_t e;
    pc        = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    InstrD    = instr;
    PCD       = pc;
    PCPlus4D  = pc + 32'd4;
    FlushE    = flush;
    RegWriteW = we;
    RdW       = rd;
    ResultW   = res;
    e = model(instr, pc, flush, rf_read(instr[19:15], we, rd, res), rf_read(instr[24:20], we, rd, res));
    exp_q.push_back(e);
    if (we && rd != 5'd0) m_rf[rd] = res;
    #1;
    check("rs_comb", 64'({Rs1D, Rs2D}), 64'({instr[19:15], instr[24:20]}));
    @(negedge clk);
  endtask

  // Monitor
  initial begin
    eout_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = eout_t'(exp_q.pop_front());
        check("ctrl", 64'({act.reg_write, act.result_src, act.mem_write, act.jump, act.branch,
                           act.alu_ctrl, act.alu_src, act.illegal}),
                      64'({e.reg_write, e.result_src, e.mem_write, e.jump, e.branch,
                           e.alu_ctrl, e.alu_src, e.illegal}));
        check("rd1", 64'(act.rd1), 64'(e.rd1));
        check("rd2", 64'(act.rd2), 64'(e.rd2));
        if (!e.illegal) check("imm", 64'(act.imm), 64'(e.imm));
        check("pc_pcp4", {act.pc, act.pcp4}, {e.pc, e.pcp4});
        check("idx", 64'({act.rs1, act.rs2, act.rd}), 64'({e.rs1, e.rs2, e.rd}));
      end
    end
  end

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    logic [31:0] instr;
    logic [6:0]  ops [6];
    logic [4:0]  rd;
    n_checks = 0;
    n_fail   = 0;
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
    ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    reset     = 1'b0;
    InstrD    = 32'h0050_0093;
    PCD       = 32'h0000_0100;
    PCPlus4D  = 32'h0000_0104;
    FlushE    = 1'b0;
    RegWriteW = 1'b0;
    RdW       = 5'd0;
    ResultW   = 32'd0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_all_zero("reset_hold");
    end
    @(negedge clk);
    reset = 1'b1;

    step(32'h0050_0093, 0, 0, 0, 0);
    step(NOP, 0, 1, 5'd2, 32'd7);
    step(NOP, 0, 1, 5'd3, 32'd3);
    step(32'h4031_00B3, 0, 0, 0, 0);
    step(32'hFE11_2E23, 0, 0, 0, 0);
    step(32'hFE00_0EE3, 0, 0, 0, 0);
    step(32'h0080_00EF, 0, 0, 0, 0);
    step(NOP, 0, 1, 5'd0, 32'h55);
    step(32'h0000_0093, 0, 0, 0, 0);
    step(NOP, 0, 1, 5'd1, 32'h1111);
    step(32'h0000_8093, 0, 1, 5'd1, 32'hABCD);
    step(32'h0000_8093, 0, 0, 0, 0);
    step(32'h0040_2183, 1, 0, 0, 0);
    step(32'h0040_2183, 0, 0, 0, 0);
    step(32'h0000_007F, 0, 0, 0, 0);

    // Asynchronous reset between edges, with the illegal instruction still held.
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_illegal", 64'(IllegalE), 64'd0);
    check_all_zero("async_rst");
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    @(negedge clk);
    reset = 1'b1;

    for (int n = 0; n < 400; n++) begin
      instr = $urandom;
      if ($urandom_range(0, 7) != 0) instr[6:0] = ops[$urandom_range(0, 5)];
      rd = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) rd = instr[19:15];
      step(instr, ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), rd, $urandom);
    end

    @(posedge clk);
    #2;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/idecode.md
Name: idecode

Overview:
- Decode stage of the 5-stage RV32I pipeline; sits directly downstream of the fetch stage.
- Consumes InstrD, PCD and PCPlus4D from the fetch stage's IF/ID register.
- Decodes control, reads the register file, extends the immediate and registers everything into the ID/EX pipeline register.
- Holds the architectural register file; its write port is driven by the writeback stage.

Parameters:
NREGS, 32, number of architectural registers; index width is $clog2(NREGS).
RF_RESET, 1, 1 = all registers cleared by reset; 0 = register contents untouched by reset.

Ports:
clk  in  1  clock, rising-edge active
reset  in  1  asynchronous, active-low reset
InstrD  in  32  instruction from IF/ID
PCD  in  32  PC of InstrD
PCPlus4D  in  32  PCD+4
FlushE  in  1  hazard unit: load a bubble into ID/EX next edge
RegWriteW  in  1  writeback write enable
RdW  in  5  writeback destination
ResultW  in  32  writeback data
Rs1D  out  5  InstrD[19:15], combinational, to hazard unit
Rs2D  out  5  InstrD[24:20], combinational, to hazard unit
RegWriteE  out  1  registered control
ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
MemWriteE  out  1  store
JumpE  out  1  jal
BranchE  out  1  beq
ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
ALUSrcE  out  1  1 = ImmExtE is ALU operand B
RD1E  out  32  rs1 data
RD2E  out  32  rs2 data
PCE  out  32  registered PCD
ImmExtE  out  32  sign-extended immediate
Rs1E  out  5  registered Rs1D
Rs2E  out  5  registered Rs2D
RdE  out  5  InstrD[11:7] registered
PCPlus4E  out  32  registered PCPlus4D
IllegalE  out  1  unsupported opcode/funct in E stage

Behaviour:
- Latency: one cycle from D to E; all E outputs are registers.
- Reset (reset=0, async): every E output is 0; with RF_RESET=1 all registers are 0. Reset wins over FlushE and RegWriteW.
- FlushE=1 at an edge: all E outputs load 0, including IllegalE. The result is a bubble with no register write, no memory write and no jump/branch.
- Main decoder by opcode InstrD[6:0]:
  - 0000011 lw: RegWrite=1, ImmSrc I, ALUSrc=1, ResultSrc=01, ALUOp 00.
  - 0100011 sw: MemWrite=1, ImmSrc S, ALUSrc=1, ALUOp 00.
  - 0110011 R-type: RegWrite=1, ALUOp 10.
  - 0010011 I-ALU: RegWrite=1, ImmSrc I, ALUSrc=1, ALUOp 10.
  - 1100011 beq: Branch=1, ImmSrc B, ALUOp 01.
  - 1101111 jal: RegWrite=1, Jump=1, ImmSrc J, ResultSrc=10.
- ALU decoder:
  - ALUOp 00 → add; 01 → sub.
  - ALUOp 10 by funct3:
    - 000: sub if opcode R-type and funct7[5]=1, else add.
    - 010: slt.
    - 110: or.
    - 111: and.
- Any other opcode, or funct3 outside this set under ALUOp 10: all control 0 and IllegalE=1 next edge. Data fields are still registered.
- Immediate extension: instruction bit 31 is the sign bit.
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - R-type: ImmExt is don't-care, registered as 0.
- Register file:
  - Two combinational read ports, indexed by Rs1D and Rs2D.
  - Write on rising clk when RegWriteW=1 and RdW≠0.
  - x0 always reads 0; writes to x0 are ignored.
- Same-edge read/write, i.e. RdW==Rs1D (or Rs2D), RdW≠0, RegWriteW=1: behaviour is set by the optional feature below.
- No stall input: the IF/ID register freezes the decode inputs. With unchanged inputs, decode recomputes identical E values every cycle.

Optional Feature:
Macro IDECODE_BYPASS_EN.
- Defined: write-through bypass. When RegWriteW=1, RdW≠0 and RdW matches a read index, that read port returns ResultW combinationally, so RD1E/RD2E capture the newly written value at the same edge.
- Undefined: the read ports return stored contents only. Same-edge operands capture the old value, and the hazard unit must stall one extra cycle.

Test Plan:
- Reset: hold reset=0 with InstrD=0x00500093 → every E output 0; release → next edge RegWriteE=1, ALUSrcE=1, ImmExtE=5, RdE=1, ALUControlE=000.
- R-type sub: x2=7, x3=3 preloaded via W port; InstrD=0x403100B3 → ALUControlE=001, RD1E=7, RD2E=3, RdE=1, ALUSrcE=0.
- Immediates:
  - sw 0xFE112E23 → ImmExtE=0xFFFFFFFC, MemWriteE=1.
  - beq 0xFE000EE3 → ImmExtE=0xFFFFFFFC, BranchE=1.
  - jal 0x008000EF → ImmExtE=8, JumpE=1, ResultSrcE=10.
- x0 and bypass:
  - Write x0=0x55 → reads 0.
  - Same edge RegWriteW=1, RdW=1, ResultW=0xABCD with Rs1D=1 → RD1E=0xABCD if IDECODE_BYPASS_EN, else old x1.
- FlushE=1 during lw 0x00402183 → next edge all E outputs 0; FlushE=0 next cycle → lw controls appear.
- Illegal opcode 0x0000007F → IllegalE=1, RegWriteE=0, MemWriteE=0; async reset asserted mid-cycle clears IllegalE immediately, without waiting for an edge.
